velocity_mem_ctrl: RTL and testbench

Sequencing and arbitration controller for one per-cell single-port velocity RAM (width DATA_WIDTH = {vz,vy,vx}; address 0 holds the cell particle count).
- On init_start it fetches the header word and publishes the particle count.
- It then shares the single RAM port between the motion-update read requester and the velocity write-back requester, and range-checks every address.
- It sits between the per-cell velocity RAM and the velocity cache / motion update logic.

---
 rtl/md_vel_ctrl_pkg.sv | 15 +
 rtl/vel_rd_pipe.sv | 42 ++++
 rtl/velocity_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_velocity_mem_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_vel_ctrl_pkg.sv
// Shared types and constants for the velocity RAM controller.
//   state_e  : controller FSM states
//   HDR_ADDR : RAM address of the header word (particle count)
package md_vel_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWait,
    StRun
  } state_e;

  localparam int unsigned HDR_ADDR = 0;

endpackage

// File: rtl/vel_rd_pipe.sv
// Read-in-flight tracker: one {valid, oob} slot per cycle of read latency.
// Ports:
//   clk, rst  : clock, synchronous active-high clear
//   push      : a read was granted this cycle
//   push_oob  : that read was out of range (answer with zero data)
//   out_valid : oldest slot reached the RAM data return cycle
//   out_oob   : that slot belongs to an out-of-range read
module vel_rd_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_oob,
  output logic out_valid,
  output logic out_oob
);

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] oob_q, oob_d;

  always_comb begin
    valid_d    = valid_q << 1;
    oob_d      = oob_q << 1;
    valid_d[0] = push;
    oob_d[0]   = push & push_oob;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      oob_q   <= '0;
    end else begin
      valid_q <= valid_d;
      oob_q   <= oob_d;
    end
  end

  assign out_valid = valid_q[Depth-1];
  assign out_oob   = oob_q[Depth-1];

endmodule

// File: rtl/velocity_mem_ctrl.sv
// Sequencing and arbitration controller for one per-cell velocity RAM.
// On init_start it reads the header word (address 0) and publishes the clamped
// particle count, then shares the single RAM port between a read requester and
// a write requester, range-checking every address.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   init_start / init_done    : start header fetch / high while running
//   particle_count            : header value, clamped to PARTICLE_NUM-1
//   rd_req/rd_addr/rd_gnt     : read request handshake
//   rd_data_valid/rd_data     : read response, in grant order
//   wr_req/wr_addr/wr_data/wr_gnt : write request handshake
//   err_oob                   : pulse on out-of-range grant or clamped header
//   ram_*                     : registered RAM port, ram_q returns read data
module velocity_mem_ctrl
  import md_vel_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned WR_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_start,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic                  err_oob,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int unsigned WaitW   = $clog2(RD_LAT + 1);
  localparam int unsigned StreakW = $clog2(WR_BURST_MAX + 1);
  localparam logic [ADDR_WIDTH-1:0] MaxCount = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [WaitW-1:0]      WaitLast = WaitW'(RD_LAT);
  localparam logic [StreakW-1:0]    BurstMax = StreakW'(WR_BURST_MAX);

  state_e                state_q, state_d;
  logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [StreakW-1:0]    streak_q, streak_d;
  logic [ADDR_WIDTH-1:0] ram_address_d;
  logic [DATA_WIDTH-1:0] ram_data_d;
  logic                  ram_rden_d, ram_wren_d;
  logic                  pipe_push, pipe_oob, pipe_valid, pipe_out_oob;

  logic [ADDR_WIDTH-1:0] hdr;
  logic                  hdr_clamp, rd_in_range, wr_in_range;

  assign hdr       = ram_q[ADDR_WIDTH-1:0];
  assign hdr_clamp = hdr > MaxCount;
  // Address 0 is the header, so it is never a legal data address.
  assign rd_in_range = (rd_addr != '0) && (rd_addr <= count_q);
  assign wr_in_range = (wr_addr != '0) && (wr_addr <= count_q);

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    count_d       = count_q;
    streak_d      = '0;
    ram_address_d = '0;
    ram_data_d    = '0;
    ram_rden_d    = 1'b0;
    ram_wren_d    = 1'b0;
    rd_gnt        = 1'b0;
    wr_gnt        = 1'b0;
    err_oob       = 1'b0;
    pipe_push     = 1'b0;
    pipe_oob      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (init_start) state_d = StFetch;
      end
      StFetch: begin
        ram_rden_d    = 1'b1;
        ram_address_d = ADDR_WIDTH'(HDR_ADDR);
        wait_cnt_d    = '0;
        state_d       = StWait;
      end
      StWait: begin
        // Covers the rden cycle plus RD_LAT cycles of RAM latency.
        if (wait_cnt_q == WaitLast) begin
          count_d = hdr_clamp ? MaxCount : hdr;
          err_oob = hdr_clamp;
          state_d = StRun;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StRun: begin
        wr_gnt = wr_req && !(rd_req && (streak_q == BurstMax));
        rd_gnt = rd_req && !wr_gnt;
        if (wr_gnt) begin
          streak_d = (streak_q == BurstMax) ? streak_q : streak_q + 1'b1;
          if (wr_in_range) begin
            ram_wren_d    = 1'b1;
            ram_address_d = wr_addr;
            ram_data_d    = wr_data;
          end else begin
            err_oob = 1'b1;
          end
        end else if (rd_gnt) begin
          pipe_push = 1'b1;
          if (rd_in_range) begin
            ram_rden_d    = 1'b1;
            ram_address_d = rd_addr;
          end else begin
            // Keeps its ordering slot, answered with zero data.
            err_oob  = 1'b1;
            pipe_oob = 1'b1;
          end
        end
        if (init_start) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      count_q     <= '0;
      streak_q    <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_rden    <= 1'b0;
      ram_wren    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      count_q     <= count_d;
      streak_q    <= streak_d;
      ram_address <= ram_address_d;
      ram_data    <= ram_data_d;
      ram_rden    <= ram_rden_d;
      ram_wren    <= ram_wren_d;
    end
  end

  vel_rd_pipe #(
    .Depth(RD_LAT + 1)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .push     (pipe_push),
    .push_oob (pipe_oob),
    .out_valid(pipe_valid),
    .out_oob  (pipe_out_oob)
  );

  assign init_done      = (state_q == StRun);
  assign particle_count = count_q;
  assign rd_data_valid  = pipe_valid;
  assign rd_data        = (pipe_valid && !pipe_out_oob) ? ram_q : '0;

endmodule

// File: tb/tb_velocity_mem_ctrl.sv
// Self-checking bench for velocity_mem_ctrl: random requesters, a behavioural
// RAM, a reference model predicting grants/RAM traffic, and a scoreboard of
// expected read responses consumed by an independent monitor.
module tb_velocity_mem_ctrl;

  localparam int DW    = 96;
  localparam int AW    = 8;
  localparam int PN    = 220;
  localparam int BURST = 4;
  localparam int LAT   = 1;

  logic          clk = 1'b0;
  logic          rst, init_start, init_done;
  logic [AW-1:0] particle_count;
  logic          rd_req, rd_gnt, rd_data_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_req, wr_gnt, err_oob;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_rden, ram_wren;

  velocity_mem_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .PARTICLE_NUM(PN),
    .RD_LAT      (LAT),
    .WR_BURST_MAX(BURST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .init_start    (init_start),
    .init_done     (init_done),
    .particle_count(particle_count),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_gnt        (wr_gnt),
    .err_oob       (err_oob),
    .ram_address   (ram_address),
    .ram_data      (ram_data),
    .ram_rden      (ram_rden),
    .ram_wren      (ram_wren),
    .ram_q         (ram_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with one cycle of read latency.
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_wren) ram[ram_address] <= ram_data;
    if (ram_rden) ram_q <= ram[ram_address];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  rd_exp_t       sb[$];
  logic [DW-1:0] ref_mem [0:255];
  bit            m_run = 0;
  int            m_count = 0;
  int            m_streak = 0;
  bit            exp_rden = 0, exp_wren = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  function automatic bit in_rng(input logic [AW-1:0] a);
    return (int'(a) >= 1) && (int'(a) <= m_count);
  endfunction

  // Monitor: consumes expected read responses whenever the DUT presents one.
  rd_exp_t mon_e;
  always @(negedge clk) begin
    if (rd_data_valid) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", rd_data_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("rd_data", rd_data, mon_e.data);
        check("rd_cycle", cyc, mon_e.due);
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      check("rd_missing", rd_data_valid, 1'b1);
      void'(sb.pop_front());
    end
  end

  // One cycle of the model: sample/check at negedge, return at posedge+1.
  task automatic run_cycle(output bit ew, output bit er);
    bit eoob;
    @(negedge clk);
    check("init_done", init_done, m_run);
    if (m_run) begin
      check("ram_rden", ram_rden, exp_rden);
      check("ram_wren", ram_wren, exp_wren);
      if (exp_rden || exp_wren) check("ram_address", ram_address, exp_addr);
      if (exp_wren) check("ram_data", ram_data, exp_wdata);
    end
    ew   = m_run && wr_req && !(rd_req && m_streak == BURST);
    er   = m_run && rd_req && !ew;
    eoob = (ew && !in_rng(wr_addr)) || (er && !in_rng(rd_addr));
    check("wr_gnt", wr_gnt, ew);
    check("rd_gnt", rd_gnt, er);
    check("err_oob", err_oob, eoob);
    exp_rden = 0;
    exp_wren = 0;
    if (ew) begin
      m_streak = (m_streak < BURST) ? m_streak + 1 : BURST;
      if (in_rng(wr_addr)) begin
        ref_mem[wr_addr] = wr_data;
        exp_wren  = 1;
        exp_addr  = wr_addr;
        exp_wdata = wr_data;
      end
    end else begin
      m_streak = 0;
    end
    if (er) begin
      sb.push_back('{data: in_rng(rd_addr) ? ref_mem[rd_addr] : '0, due: cyc + LAT + 1});
      if (in_rng(rd_addr)) begin
        exp_rden = 1;
        exp_addr = rd_addr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic traffic(input int n, input int p_rd, input int p_wr, input int amax);
    bit ew, er;
    for (int i = 0; i < n; i++) begin
      if (!rd_req && $urandom_range(99) < p_rd) begin
        rd_req  = 1;
        rd_addr = AW'($urandom_range(amax));
      end
      if (!wr_req && $urandom_range(99) < p_wr) begin
        wr_req  = 1;
        wr_addr = AW'($urandom_range(amax));
        wr_data = {$urandom(), $urandom(), $urandom()};
      end
      run_cycle(ew, er);
      if (ew) wr_req = 0;
      if (er) rd_req = 0;
    end
  endtask

  task automatic drain();
    bit ew, er;
    rd_req = 0;
    wr_req = 0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) run_cycle(ew, er);
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic do_init(input logic [AW-1:0] hdr);
    int exp_cnt;
    exp_cnt = (int'(hdr) > PN - 1) ? PN - 1 : int'(hdr);
    ram[0] = {$urandom(), $urandom(), $urandom()};
    ram[0][AW-1:0] = hdr;
    rd_req = 0;
    wr_req = 0;
    init_start = 1;
    @(posedge clk);
    #1;
    init_start = 0;
    m_run = 0;
    @(negedge clk);
    check("fetch_init_done", init_done, 1'b0);
    check("fetch_rden", ram_rden, 1'b0);
    @(negedge clk);
    check("hdr_rden", ram_rden, 1'b1);
    check("hdr_addr", ram_address, '0);
    check("hdr_wren", ram_wren, 1'b0);
    @(negedge clk);
    check("wait_init_done", init_done, 1'b0);
    check("hdr_clamp_oob", err_oob, int'(hdr) > PN - 1);
    @(negedge clk);
    check("run_init_done", init_done, 1'b1);
    check("particle_count", particle_count, exp_cnt);
    check("run_oob", err_oob, 1'b0);
    @(posedge clk);
    #1;
    m_run    = 1;
    m_count  = exp_cnt;
    m_streak = 0;
    exp_rden = 0;
    exp_wren = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_init_done"}, init_done, 1'b0);
    check({tag, "_count"}, particle_count, '0);
    check({tag, "_rd_valid"}, rd_data_valid, 1'b0);
    check({tag, "_rd_data"}, rd_data, '0);
    check({tag, "_ram_rden"}, ram_rden, 1'b0);
    check({tag, "_ram_wren"}, ram_wren, 1'b0);
    check({tag, "_ram_addr"}, ram_address, '0);
    check({tag, "_ram_data"}, ram_data, '0);
    check({tag, "_err_oob"}, err_oob, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit ew, er;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = {$urandom(), $urandom(), $urandom()};
      ref_mem[i] = ram[i];
    end
    ram_q      = '0;
    rst        = 1;
    init_start = 0;
    rd_req     = 0;
    wr_req     = 0;
    rd_addr    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    // Header fetch, count 37
    do_init(8'd37);

    // Directed read of address 5
    ram[5]     = {32'hA, 32'hB, 32'hC};
    ref_mem[5] = ram[5];
    rd_req  = 1;
    rd_addr = 8'd5;
    run_cycle(ew, er);
    if (er) rd_req = 0;
    drain();

    // Both requesters saturated: W,W,W,W,R pattern
    traffic(20, 100, 100, 45);
    drain();

    // In-range read, then out-of-range read and header write
    rd_req = 1; rd_addr = 8'd5;
    run_cycle(ew, er); if (er) rd_req = 0;
    rd_req = 1; rd_addr = 8'd40;
    run_cycle(ew, er); if (er) rd_req = 0;
    wr_req = 1; wr_addr = 8'd0; wr_data = 96'h5A5A;
    run_cycle(ew, er); if (ew) wr_req = 0;
    drain();

    // Write then immediate read of the same address
    wr_req = 1; wr_addr = 8'd9; wr_data = 96'h123;
    run_cycle(ew, er); if (ew) wr_req = 0;
    rd_req = 1; rd_addr = 8'd9;
    run_cycle(ew, er); if (er) rd_req = 0;
    drain();

    // Random mixed traffic, small address window to get read-after-write hits
    traffic(300, 50, 50, 40);

    // Re-init from RUN with reads in flight; clamped header
    traffic(5, 100, 30, 37);
    do_init(8'd250);
    traffic(200, 60, 60, 230);
    drain();

    // Reset with reads in flight
    traffic(6, 100, 20, 219);
    rst    = 1;
    rd_req = 0;
    wr_req = 0;
    @(posedge clk);
    #1;
    rst   = 0;
    m_run = 0;
    m_count = 0;
    m_streak = 0;
    while (sb.size() > 0 && sb[sb.size() - 1].due >= cyc) void'(sb.pop_back());
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rd_req = 1; rd_addr = 8'd3;
    wr_req = 1; wr_addr = 8'd4;
    for (int i = 0; i < 4; i++) run_cycle(ew, er);
    rd_req = 0;
    wr_req = 0;

    // Boundary headers: zero count, and exactly PARTICLE_NUM-1
    do_init(8'd0);
    traffic(30, 50, 50, 5);
    drain();
    do_init(8'd219);
    traffic(100, 50, 50, 225);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
